// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle MIPS datapath and its control FSM.
// The master side is the controller; the slave side is the datapath.
interface multicycle_ctrl_if;
  logic [5:0] op;
  logic       zero;
  logic       stall;
  logic       pcen;
  logic       irwrite;
  logic       memwrite;
  logic       regwrite;
  logic       iord;
  logic       memtoreg;
  logic       regdst;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic [1:0] pcsrc;
  logic       extop;
  logic       illegal_op;
  logic [3:0] state_o;

  modport master (
    input  op, zero, stall,
    output pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst,
           alusrca, alusrcb, aluop, pcsrc, extop, illegal_op, state_o
  );

  modport slave (
    output op, zero, stall,
    input  pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst,
           alusrca, alusrcb, aluop, pcsrc, extop, illegal_op, state_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main Moore control FSM for the multi-cycle MIPS datapath.
// Sequences fetch/decode/execute/writeback and drives all selects and strobes.
module multicycle_ctrl #(
  parameter bit EN_ORI = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ORIEX   = 4'd10,
    IMMWB   = 4'd11,
    JEX     = 4'd12
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t     r_state;
  state_t     w_next;
  logic       w_pcwrite;
  logic       w_branch;
  logic       w_irwrite;
  logic       w_memwrite;
  logic       w_regwrite;
  logic       w_iord;
  logic       w_memtoreg;
  logic       w_regdst;
  logic       w_alusrca;
  logic [1:0] w_alusrcb;
  logic [1:0] w_aluop;
  logic [1:0] w_pcsrc;
  logic       w_extop;
  logic       w_illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_irwrite  = 1'b0;
    w_memwrite = 1'b0;
    w_regwrite = 1'b0;
    w_iord     = 1'b0;
    w_memtoreg = 1'b0;
    w_regdst   = 1'b0;
    w_alusrca  = 1'b0;
    w_alusrcb  = 2'b00;
    w_aluop    = 2'b00;
    w_pcsrc    = 2'b00;
    w_extop    = 1'b1;
    w_illegal  = 1'b0;
    case (r_state)
      FETCH: begin
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
        w_alusrcb = 2'b01;
        w_next    = DECODE;
      end
      DECODE: begin
        w_alusrcb = 2'b11;
        case (bus.op)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_RTYP:      w_next = RTYPEEX;
          OP_BEQ:       w_next = BEQEX;
          OP_ADDI:      w_next = ADDIEX;
          OP_J:         w_next = JEX;
          OP_ORI: begin
            if (EN_ORI) begin
              w_next = ORIEX;
            end else begin
              w_next    = FETCH;
              w_illegal = 1'b1;
            end
          end
          default: begin
            w_next    = FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_next    = (bus.op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        w_iord = 1'b1;
        w_next = MEMWB;
      end
      MEMWB: begin
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
        w_next     = FETCH;
      end
      MEMWR: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
        w_next     = FETCH;
      end
      RTYPEEX: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b10;
        w_next    = RTYPEWB;
      end
      RTYPEWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
        w_next     = FETCH;
      end
      BEQEX: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b01;
        w_pcsrc   = 2'b01;
        w_branch  = 1'b1;
        w_next    = FETCH;
      end
      ADDIEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_next    = IMMWB;
      end
      ORIEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_aluop   = 2'b11;
        w_extop   = 1'b0;
        w_next    = IMMWB;
      end
      IMMWB: begin
        w_regwrite = 1'b1;
        w_next     = FETCH;
      end
      JEX: begin
        w_pcsrc   = 2'b10;
        w_pcwrite = 1'b1;
        w_next    = FETCH;
      end
      default: w_next = FETCH;
    endcase
    if (bus.stall) w_next = r_state;
  end

  // rst gates outputs combinationally so strobes drop the moment it rises
  assign bus.pcen       = ~rst & ~bus.stall & (w_pcwrite | (w_branch & bus.zero));
  assign bus.irwrite    = ~rst & ~bus.stall & w_irwrite;
  assign bus.memwrite   = ~rst & ~bus.stall & w_memwrite;
  assign bus.regwrite   = ~rst & ~bus.stall & w_regwrite;
  assign bus.illegal_op = ~rst & ~bus.stall & w_illegal;
  assign bus.iord       = ~rst & w_iord;
  assign bus.memtoreg   = ~rst & w_memtoreg;
  assign bus.regdst     = ~rst & w_regdst;
  assign bus.alusrca    = ~rst & w_alusrca;
  assign bus.alusrcb    = rst ? 2'b00 : w_alusrcb;
  assign bus.aluop      = rst ? 2'b00 : w_aluop;
  assign bus.pcsrc      = rst ? 2'b00 : w_pcsrc;
  assign bus.extop      = rst | w_extop;
  assign bus.state_o    = rst ? 4'd0 : r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl (EN_ORI=1 and EN_ORI=0 instances)
// against an instruction-path reference model.
module tb_multicycle_ctrl;

  typedef int iq_t[$];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus_a ();
  multicycle_ctrl_if bus_b ();

  multicycle_ctrl #(.EN_ORI(1'b1)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a.master));
  multicycle_ctrl #(.EN_ORI(1'b0)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b.master));

  logic [19:0] obs_a, obs_b;
  assign obs_a = {bus_a.pcen, bus_a.irwrite, bus_a.memwrite, bus_a.regwrite, bus_a.iord,
                  bus_a.memtoreg, bus_a.regdst, bus_a.alusrca, bus_a.alusrcb, bus_a.aluop,
                  bus_a.pcsrc, bus_a.extop, bus_a.illegal_op, bus_a.state_o};
  assign obs_b = {bus_b.pcen, bus_b.irwrite, bus_b.memwrite, bus_b.regwrite, bus_b.iord,
                  bus_b.memtoreg, bus_b.regdst, bus_b.alusrca, bus_b.alusrcb, bus_b.aluop,
                  bus_b.pcsrc, bus_b.extop, bus_b.illegal_op, bus_b.state_o};

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %05h expected %05h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Sequence of states visited after FETCH for one instruction, ending back at FETCH
  function automatic iq_t path(input logic [5:0] o, input bit en);
    iq_t p;
    p.push_back(1);
    case (o)
      6'b100011: begin p.push_back(2); p.push_back(3); p.push_back(4); end
      6'b101011: begin p.push_back(2); p.push_back(5); end
      6'b000000: begin p.push_back(6); p.push_back(7); end
      6'b000100: p.push_back(8);
      6'b001000: begin p.push_back(9); p.push_back(11); end
      6'b001101: if (en) begin p.push_back(10); p.push_back(11); end
      6'b000010: p.push_back(12);
      default: ;
    endcase
    p.push_back(0);
    return p;
  endfunction

  function automatic logic [19:0] exp_out(input int st, input logic [5:0] o, input bit en,
                                          input logic z, input logic s, input logic r);
    logic pcw, br, irw, mw, rw, io, mtr, rd, asa, ext, ill;
    logic [1:0] asb, aop, psrc;
    iq_t p;
    logic [3:0] st4;
    if (r) return 20'h00020;
    {pcw, br, irw, mw, rw, io, mtr, rd, asa, ill} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00; ext = 1'b1;
    st4 = 4'(st);
    case (st)
      0:  begin irw = 1; pcw = 1; asb = 2'b01; end
      1:  begin asb = 2'b11; p = path(o, en); ill = (p.size() == 2); end
      2:  begin asa = 1; asb = 2'b10; end
      3:  io = 1;
      4:  begin mtr = 1; rw = 1; end
      5:  begin io = 1; mw = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rd = 1; rw = 1; end
      8:  begin asa = 1; aop = 2'b01; psrc = 2'b01; br = 1; end
      9:  begin asa = 1; asb = 2'b10; end
      10: begin asa = 1; asb = 2'b10; aop = 2'b11; ext = 0; end
      11: rw = 1;
      12: begin psrc = 2'b10; pcw = 1; end
      default: ;
    endcase
    return {(pcw | (br & z)) & ~s, irw & ~s, mw & ~s, rw & ~s, io, mtr, rd, asa,
            asb, aop, psrc, ext, ill & ~s, st4};
  endfunction

  function automatic logic [5:0] pick_op();
    logic [5:0] tbl [8];
    int unsigned k;
    tbl = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
            6'b001000, 6'b001101, 6'b000010, 6'b111111};
    k = $urandom_range(0, 9);
    if (k >= 8) return 6'($urandom());
    return tbl[k];
  endfunction

  int  st_a, st_b;
  iq_t q_a, q_b;
  logic stall, zero;

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    zero = 1'b0;
    bus_a.op = 6'b0; bus_b.op = 6'b0;
    bus_a.stall = 1'b0; bus_b.stall = 1'b0;
    bus_a.zero = 1'b0; bus_b.zero = 1'b0;
    st_a = 0; st_b = 0;
    #1;
    check("reset_a", obs_a, 20'h00020);
    check("reset_b", obs_b, 20'h00020);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int unsigned cyc = 0; cyc < 3000; cyc++) begin
      stall = ($urandom_range(0, 3) == 0);
      zero  = 1'($urandom());
      if (st_a == 0) bus_a.op = pick_op();
      if (st_b == 0) bus_b.op = pick_op();
      bus_a.stall = stall; bus_b.stall = stall;
      bus_a.zero  = zero;  bus_b.zero  = zero;
      #1;
      check("cycle_a", obs_a, exp_out(st_a, bus_a.op, 1'b1, zero, stall, rst));
      check("cycle_b", obs_b, exp_out(st_b, bus_b.op, 1'b0, zero, stall, rst));

      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        st_a = 0; st_b = 0;
        q_a.delete(); q_b.delete();
        #1;
        check("midrst_a", obs_a, 20'h00020);
        check("midrst_b", obs_b, 20'h00020);
      end

      @(posedge clk);
      #1;
      if (!rst && !stall) begin
        if (q_a.size() == 0) q_a = path(bus_a.op, 1'b1);
        st_a = q_a.pop_front();
        if (q_b.size() == 0) q_b = path(bus_b.op, 1'b0);
        st_b = q_b.pop_front();
      end
      rst = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
